even_writeback_pipe: RTL
========================

EVEN_WRITEBACK_PIPE -- requirements
Module: even_writeback_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 7, number of staging stages; the last stage is the register-file writeback stage.
REQ-002 SHALL have port clock, input, 1, the single clock, rising-edge active.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, even-pipe issues a result this cycle.
REQ-005 SHALL have port in_result, input, 128, even-pipe result value (bit 0 = MSB).
REQ-006 SHALL have port in_rt, input, 7, destination register address.
REQ-007 SHALL have port in_wr_en, input, 1, result writes the register file.
REQ-008 SHALL have port in_latency, input, 3, unit latency 2..7 cycles; the value is ready from that stage onward.
REQ-009 SHALL have port flush, input, 1, kills speculative entries (stages 1..3).
REQ-010 SHALL have port fwd_addr, input, 7, forwarding query register address.
REQ-011 SHALL have port fwd_hit, output, 1, a matching ready value is present.
REQ-012 SHALL have port fwd_data, output, 128, forwarded value.
REQ-013 SHALL have port fwd_pending, output, 1, the youngest match is not yet ready; issue must stall.
REQ-014 SHALL have port wb_en, output, 1, register-file write strobe.
REQ-015 SHALL have port wb_addr, output, 7, register-file write address.
REQ-016 SHALL have port wb_data, output, 128, register-file write data.

Function
REQ-017 SHALL hold entries of {valid, wr_en, rt, latency, result} in stages 1..DEPTH and shift every cycle, with no stall input.
REQ-018 SHALL load stage 1 on in_valid=1; when in_valid=0, stage 1 becomes invalid.
REQ-019 SHALL mark a stage-k entry ready when k >= in_latency.
REQ-020 SHALL clamp in_latency values 0 or 1 to 2 and values above DEPTH to DEPTH.
REQ-021 SHALL drive wb_en = valid AND wr_en of stage DEPTH, with wb_addr and wb_data taken from stage DEPTH.
REQ-022 SHALL drive wb_addr and wb_data to zero when wb_en=0.
REQ-023 SHALL, for forwarding, search stages 1..DEPTH for valid, wr_en entries with rt == fwd_addr; the lowest-numbered (youngest) match wins.
REQ-024 SHALL, when the youngest match is ready, set fwd_hit=1 and fwd_data to that entry's result, with fwd_pending=0.
REQ-025 SHALL, when the youngest match is not ready, set fwd_pending=1 and fwd_hit=0, and never fall through to an older match.
REQ-026 SHALL, when there is no match, set fwd_hit=0, fwd_pending=0 and fwd_data=0.
REQ-027 SHALL compute the forwarding outputs combinationally from current stage contents, with zero-cycle latency.
REQ-028 SHALL, on flush in a cycle, invalidate stages 1..3 after the edge; entries in stages 4..DEPTH still advance and write back.
REQ-029 SHALL, when flush and in_valid coincide, drop the incoming entry.
REQ-030 SHALL deliver an entry issued at cycle N to wb_en in cycle N+DEPTH.

Reset
REQ-031 SHALL, while reset=0, asynchronously clear all valid bits and all stage fields to zero.
REQ-032 SHALL hold all outputs at zero during reset.
REQ-033 SHALL discard in-flight entries on reset asserted mid-operation, with no writeback after release.
REQ-034 SHALL accept in_valid on the first rising edge after reset release.

Structure
REQ-035 SHALL place the stage-entry struct, the DEPTH default and the speculative-stage boundary constant (3) in the shared descriptions package.
REQ-036 SHALL implement forwarding selection as sub-module fwd_select (priority search over stage entries).

Verification
REQ-037 SHALL cover: issue rt=5, result=30, latency=2, wr_en=1 at cycle 0 -> wb_en=1, wb_addr=5, wb_data=30 at cycle 7 only.
REQ-038 SHALL cover: rt=9, latency=4, fwd_addr=9 -> fwd_pending=1 in the cycles the entry sits in stages 1..3, then fwd_hit=1 with the value in stages 4..7.
REQ-039 SHALL cover: rt=3 value 10 issued, then rt=3 value 20 (latency 6) issued next cycle -> fwd_pending=1 (no fall-through to 10) until the younger entry is ready, then fwd_data=20.
REQ-040 SHALL cover: entries in stages 2 and 5, flush=1 -> only the stage-5 entry writes back; a concurrent in_valid is dropped.
REQ-041 SHALL cover: wr_en=0 entry rt=4 -> no wb_en, and fwd_addr=4 gives fwd_hit=0 and fwd_pending=0.
REQ-042 SHALL cover: reset pulse while three entries are in flight -> all outputs 0 immediately and no writebacks after release.

Source files
------------

// File: rtl/even_writeback_pipe_pkg.sv
// ============================================================================
// Module   : even_writeback_pipe_pkg
// Purpose  : Shared stage-entry type and constants for the even writeback pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

package even_writeback_pipe_pkg;

  localparam int c_depth_default = 7;
  localparam int c_spec_stages   = 3;

  typedef struct packed {
    logic           valid;
    logic           wr_en;
    logic [6:0]     rt;
    logic [2:0]     latency;
    logic [0:127]   result;
  } stage_t;

  // Unit latencies below 2 are not physical; latencies past the last stage saturate.
  function automatic logic [2:0] clamp_latency(input logic [2:0] lat, input int depth);
    logic [2:0] r;
    r = lat;
    if (lat < 3'd2)
      r = 3'd2;
    else if (int'(lat) > depth)
      r = 3'(depth);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/even_writeback_pipe_fwd_select.sv
// ============================================================================
// Module   : fwd_select
// Purpose  : Youngest-match priority search over pipe stages for forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fwd_select
  import even_writeback_pipe_pkg::*;
#(
  parameter int DEPTH = c_depth_default
) (
  input  stage_t [DEPTH-1:0] stages,
  input  logic [6:0]         addr,
  output logic               hit,
  output logic               pending,
  output logic [0:127]       data
);

  logic w_found;

  // Index 0 is stage 1; the first match found is the youngest and is final.
  always_comb begin
    hit     = 1'b0;
    pending = 1'b0;
    data    = '0;
    w_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_found && stages[i].valid && stages[i].wr_en && (stages[i].rt == addr)) begin
        w_found = 1'b1;
        if ((i + 1) >= int'(stages[i].latency)) begin
          hit  = 1'b1;
          data = stages[i].result;
        end else begin
          pending = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/even_writeback_pipe.sv
// ============================================================================
// Module   : even_writeback_pipe
// Purpose  : Fixed-depth result staging pipe with forwarding and RF writeback.
// Revision : 1.0
// ============================================================================
`default_nettype none

module even_writeback_pipe
  import even_writeback_pipe_pkg::*;
#(
  parameter int DEPTH = c_depth_default
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [0:127] in_result,
  input  logic [6:0]   in_rt,
  input  logic         in_wr_en,
  input  logic [2:0]   in_latency,
  input  logic         flush,
  input  logic [6:0]   fwd_addr,
  output logic         fwd_hit,
  output logic [0:127] fwd_data,
  output logic         fwd_pending,
  output logic         wb_en,
  output logic [6:0]   wb_addr,
  output logic [0:127] wb_data
);

  stage_t [DEPTH-1:0] r_stage;
  stage_t             w_in_entry;
  stage_t             w_last;

  always_comb begin
    w_in_entry         = '0;
    w_in_entry.valid   = 1'b1;
    w_in_entry.wr_en   = in_wr_en;
    w_in_entry.rt      = in_rt;
    w_in_entry.latency = clamp_latency(in_latency, DEPTH);
    w_in_entry.result  = in_result;
  end

  // r_stage[i] holds stage i+1; a flush kills whatever currently sits in stages 1..3.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= (in_valid && !flush) ? w_in_entry : '0;
      for (int i = 1; i < DEPTH; i++) begin
        if (flush && (i <= c_spec_stages))
          r_stage[i] <= '0;
        else
          r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign w_last  = r_stage[DEPTH-1];
  assign wb_en   = w_last.valid & w_last.wr_en;
  assign wb_addr = wb_en ? w_last.rt : '0;
  assign wb_data = wb_en ? w_last.result : '0;

  fwd_select #(
    .DEPTH(DEPTH)
  ) u_fwd_select (
    .stages  (r_stage),
    .addr    (fwd_addr),
    .hit     (fwd_hit),
    .pending (fwd_pending),
    .data    (fwd_data)
  );

endmodule

`default_nettype wire
